// File: rtl/ascon_state_bank.sv
// ascon_state_bank
//
// Holds the ASCON permutation state as NUM_WORDS words of WORD_W bits behind a
// single-command interface. It sits between the controller FSM and the round
// datapath. It supports full load, single-word write and XOR, a word-by-word
// clear sweep, and an optional snapshot/restore shadow copy. It also tracks
// state validity, keeps a saturating update count and a sticky error flag.
//
// Build option:
//   STATE_SNAPSHOT_EN  When defined, a shadow copy of the state and a
//                      shadow-valid bit are built, and SNAPSHOT/RESTORE are
//                      legal. When undefined, no shadow storage exists, and
//                      SNAPSHOT/RESTORE are treated as illegal commands.
//
// Ports:
//   clock_i        rising-edge clock
//   resetb_i       synchronous active-low reset
//   op_valid_i     command valid
//   op_ready_o     command ready (low while a CLEAR sweep runs)
//   op_code_i      0 NOP, 1 LOAD, 2 WRITE_WORD, 3 XOR_WORD, 4 CLEAR,
//                  5 SNAPSHOT, 6 RESTORE, 7 reserved
//   word_sel_i     target word for WRITE_WORD / XOR_WORD
//   word_data_i    operand for WRITE_WORD / XOR_WORD
//   load_i         full state for LOAD, word i at [i*WORD_W +: WORD_W]
//   state_o        registered state, same packing as load_i
//   state_valid_o  state holds meaningful data
//   update_cnt_o   saturating count of state-modifying commands
//   busy_o         CLEAR sweep in progress (inverse of op_ready_o)
//   err_o          sticky illegal-command flag, cleared only by reset
//
// FSM states:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | ready for commands
//   CLEARING | zeroing words 1..NUM_WORDS-1, one per cycle; input ignored

module ascon_state_bank #(
    parameter int NUM_WORDS = 5,
    parameter int WORD_W    = 64,
    parameter int CNT_W     = 8
) (
    input  logic                          clock_i,
    input  logic                          resetb_i,
    input  logic                          op_valid_i,
    output logic                          op_ready_o,
    input  logic [2:0]                    op_code_i,
    input  logic [$clog2(NUM_WORDS)-1:0]  word_sel_i,
    input  logic [WORD_W-1:0]             word_data_i,
    input  logic [NUM_WORDS*WORD_W-1:0]   load_i,
    output logic [NUM_WORDS*WORD_W-1:0]   state_o,
    output logic                          state_valid_o,
    output logic [CNT_W-1:0]              update_cnt_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int SEL_W = $clog2(NUM_WORDS);
    // One extra bit so that word_sel_i can be range-checked without wrapping.
    localparam logic [SEL_W:0]   NUM_WORDS_X = (SEL_W + 1)'(NUM_WORDS);
    localparam logic [SEL_W-1:0] LAST_WORD   = SEL_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD     = 3'd1,
        OP_WRITE    = 3'd2,
        OP_XOR      = 3'd3,
        OP_CLEAR    = 3'd4,
        OP_SNAPSHOT = 3'd5,
        OP_RESTORE  = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } fsm_e;

    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] state_t;

    fsm_e             fsm_q, fsm_d;
    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] sweep_q, sweep_d;
    logic             count_en;
    logic             sel_ok;

`ifdef STATE_SNAPSHOT_EN
    state_t           shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;
`endif

    assign sel_ok = ({1'b0, word_sel_i} < NUM_WORDS_X);

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sweep_d  = sweep_q;
        count_en = 1'b0;
`ifdef STATE_SNAPSHOT_EN
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
`endif

        case (fsm_q)
            IDLE: begin
                if (op_valid_i) begin
                    case (op_code_i)
                        OP_NOP: ;
                        OP_LOAD: begin
                            state_d  = state_t'(load_i);
                            valid_d  = 1'b1;
                            count_en = 1'b1;
                        end
                        OP_WRITE: begin
                            if (sel_ok) begin
                                state_d[word_sel_i] = word_data_i;
                                count_en            = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_XOR: begin
                            if (sel_ok) begin
                                state_d[word_sel_i] = state_q[word_sel_i] ^ word_data_i;
                                count_en            = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            // Word 0 is zeroed on the accept edge; the sweep
                            // covers the rest, so NUM_WORDS-1 busy cycles.
                            state_d[0] = '0;
                            valid_d    = 1'b0;
                            sweep_d    = SEL_W'(1);
                            fsm_d      = CLEARING;
                            count_en   = 1'b1;
                        end
`ifdef STATE_SNAPSHOT_EN
                        OP_SNAPSHOT: begin
                            shadow_d       = state_q;
                            shadow_valid_d = valid_q;
                        end
                        OP_RESTORE: begin
                            state_d  = shadow_q;
                            valid_d  = shadow_valid_q;
                            count_en = 1'b1;
                        end
`else
                        OP_SNAPSHOT: err_d = 1'b1;
                        OP_RESTORE:  err_d = 1'b1;
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            CLEARING: begin
                state_d[sweep_q] = '0;
                sweep_d          = sweep_q + 1'b1;
                if (sweep_q == LAST_WORD) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        // Saturate rather than wrap so a long-running session never looks fresh.
        if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            sweep_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sweep_q <= sweep_d;
        end
    end

`ifdef STATE_SNAPSHOT_EN
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end
`endif

    assign state_o       = state_q;
    assign state_valid_o = valid_q;
    assign update_cnt_o  = cnt_q;
    assign err_o         = err_q;
    assign op_ready_o    = (fsm_q == IDLE);
    assign busy_o        = (fsm_q != IDLE);

endmodule

// File: doc/ascon_state_bank.md
Name: ascon_state_bank

Overview:
- Parametrised successor to the plain state register: holds the permutation state S as NUM_WORDS words of WORD_W bits behind a command interface.
- Supports full load, single-word write, single-word XOR (absorb/key-injection), a word-by-word clear sequence, and an optional snapshot/restore shadow copy.
- Sits between the ASCON controller FSM and the permutation/round datapath.
- Tracks state validity, counts state updates and flags illegal commands.

Parameters:
- NUM_WORDS, 5, number of state words (must be >= 2).
- WORD_W, 64, width of each state word in bits.
- CNT_W, 8, width of the update counter.

Ports:
- clock_i  in  1  single clock; all logic on its rising edge.
- resetb_i  in  1  reset, synchronous, active-low.
- op_valid_i  in  1  command valid.
- op_ready_o  out  1  command ready; a command is accepted on an edge where op_valid_i=1 and op_ready_o=1.
- op_code_i  in  3  command code: 0 NOP, 1 LOAD, 2 WRITE_WORD, 3 XOR_WORD, 4 CLEAR, 5 SNAPSHOT, 6 RESTORE, 7 reserved.
- word_sel_i  in  $clog2(NUM_WORDS)  target word for WRITE_WORD and XOR_WORD.
- word_data_i  in  WORD_W  operand for WRITE_WORD and XOR_WORD.
- load_i  in  NUM_WORDS*WORD_W  full state for LOAD; word i occupies bits [i*WORD_W +: WORD_W].
- state_o  out  NUM_WORDS*WORD_W  registered state, same packing as load_i.
- state_valid_o  out  1  state holds meaningful data.
- update_cnt_o  out  CNT_W  saturating count of state-modifying commands.
- busy_o  out  1  CLEAR sequence in progress; equals ~op_ready_o.
- err_o  out  1  sticky illegal-command flag.

Behaviour:
- Reset (resetb_i=0 at an edge) overrides everything, including a CLEAR in progress:
  - state_o=0 and shadow=0;
  - state_valid_o=0, shadow_valid=0;
  - update_cnt_o=0, err_o=0;
  - FSM=IDLE, op_ready_o=1, busy_o=0.
- Latency: an accepted command takes effect on its accept edge; state_o shows the result in the following cycle. No combinational path exists from inputs to state_o.
- While op_valid_i=0 or op_ready_o=0, all state holds.
- FSM states: IDLE and CLEARING.
- IDLE: op_ready_o=1. Accepted commands behave as follows:
  - NOP: no change.
  - LOAD: state<=load_i; state_valid_o<=1.
  - WRITE_WORD: word[word_sel_i]<=word_data_i; state_valid_o unchanged.
  - XOR_WORD: word[word_sel_i]<=word[word_sel_i]^word_data_i; state_valid_o unchanged.
  - CLEAR: word 0<=0; state_valid_o<=0; sweep counter<=1; go to CLEARING. If NUM_WORDS... (must be >= 2, so CLEARING is always entered).
  - SNAPSHOT: shadow<=state; shadow_valid<=state_valid_o.
  - RESTORE: state<=shadow; state_valid_o<=shadow_valid. If shadow_valid=0, state becomes the shadow content (zeros after reset).
  - Code 7: no state change; err_o<=1.
- WRITE_WORD or XOR_WORD with word_sel_i >= NUM_WORDS: no state change, no count increment; err_o<=1.
- CLEARING: op_ready_o=0, busy_o=1. Each edge zeroes word[sweep counter] and increments the counter. After word NUM_WORDS-1 is zeroed, return to IDLE. op_ready_o is therefore low for exactly NUM_WORDS-1 cycles after the accept edge. op_valid_i is ignored during CLEARING.
- update_cnt_o: +1 on each accepted LOAD, legal WRITE_WORD, legal XOR_WORD, CLEAR (counted once, at acceptance) and RESTORE. It saturates at 2^CNT_W-1 and never wraps. NOP, SNAPSHOT and illegal commands do not count.
- err_o is cleared only by reset.

Optional Feature:
- STATE_SNAPSHOT_EN defined: shadow register and shadow_valid are present; SNAPSHOT and RESTORE behave as above.
- STATE_SNAPSHOT_EN undefined: no shadow storage is built. SNAPSHOT and RESTORE are illegal: no state change, no count increment, err_o<=1.

Test Plan:
- Reset, then LOAD with words 0..4 = 0x1111..11, 0x2222..22, ..., 0x5555..55 -> next cycle state_o matches load_i, state_valid_o=1, update_cnt_o=1, err_o=0.
- After that load, XOR_WORD sel=2 data=0xFFFF_FFFF_FFFF_FFFF -> word 2 becomes 0xCCCC_CCCC_CCCC_CCCC, all other words unchanged, update_cnt_o=2.
- CLEAR on the loaded state -> op_ready_o low for 4 cycles; words zero one per cycle in order 0..4; state_valid_o=0 from the cycle after acceptance; update_cnt_o increments by exactly 1; a LOAD offered during busy is not accepted.
- With STATE_SNAPSHOT_EN: LOAD A, SNAPSHOT, WRITE_WORD sel=0 data=0, RESTORE -> state_o==A and state_valid_o=1. Without the macro: the same sequence sets err_o=1 and leaves word 0 = 0.
- WRITE_WORD sel=5 (NUM_WORDS=5), then op_code 7 -> state unchanged, count unchanged, err_o=1 and stays set until reset.
- Pulse resetb_i=0 for one edge during cycle 2 of CLEARING -> the following cycle shows all outputs at reset values and op_ready_o=1. Separately, 300 legal LOADs with CNT_W=8 -> update_cnt_o=255.
